sysid_checker: RTL and testbench
================================

# sysid_checker

Avalon-MM read master that sits directly downstream of the system ID slave and consumes its two 32-bit words: the ID word (address 0) and the build timestamp (address 1). After reset, on request, or periodically, it reads both words, compares them with the values the software image was built against, and publishes pass/fail flags. The flags feed the boot-status LEDs and a status register, so a mismatched bitstream/software pairing is caught before the CPU runs application code.

## Interface
Parameters:
- EXPECTED_ID, 31: expected word at sysid address 0.
- EXPECTED_TIMESTAMP, 1718188374: expected word at sysid address 1.
- READ_LATENCY, 0: slave read latency L in cycles, legal range 0–3. The sysid slave is combinational, so L = 0.
- AUTO_START, 1: when 1, a check starts automatically in the first cycle after reset deasserts.
- RECHECK_PERIOD, 0: idle cycles between automatic rechecks; 0 disables rechecks. Legal range 0 or 4 to 2^24−1.

Ports:
- clock  in  1: sole clock; all logic rises on it.
- reset  in  1: synchronous, active-high reset.
- start  in  1: single-cycle check request, sampled only in IDLE.
- sysid_address  out  1: slave word address.
- sysid_read  out  1: read strobe.
- sysid_readdata  in  32: slave read data.
- busy  out  1: high while a check is in progress.
- done  out  1: one-cycle pulse when results update.
- id_ok  out  1: last captured ID equals EXPECTED_ID.
- ts_ok  out  1: last captured timestamp equals EXPECTED_TIMESTAMP.
- error_sticky  out  1: set by any failed check; cleared only by reset.
- captured_id  out  32: last ID word read.
- captured_ts  out  32: last timestamp word read.
- check_count  out  8: completed checks, saturates at 255.

## Operation
- FSM states: IDLE, RD_ID, RD_TS, DONE.
- IDLE → RD_ID when any of these holds: start = 1; the AUTO_START trigger is pending (set by reset, consumed on entry to RD_ID); or the recheck counter expires.
- RD_ID: sysid_address = 0 and sysid_read = 1 for exactly L+1 cycles. sysid_readdata is captured into a holding register on the last of these cycles, then the FSM moves to RD_TS.
- RD_TS: same as RD_ID with sysid_address = 1. On exit, captured_id and captured_ts load together from their holding registers, and the FSM moves to DONE.
- DONE (one cycle):
  - done = 1.
  - id_ok and ts_ok are registered from 32-bit equality compares.
  - error_sticky |= !(id_ok && ts_ok).
  - check_count increments, saturating at 255.
  - Next state is IDLE.
- Outside RD_ID and RD_TS, sysid_read = 0 and sysid_address = 0.
- busy = 1 in RD_ID, RD_TS and DONE.
- Recheck counter:
  - Runs only in IDLE when RECHECK_PERIOD ≠ 0 and at least one check has completed.
  - Reloads to RECHECK_PERIOD−1 on entering IDLE and triggers at 0.
  - It is the single trigger source, so start and an expiry in the same cycle start one check.
- start asserted while busy is ignored; it is not queued.

## Timing
- Reset values: busy 0, done 0, id_ok 0, ts_ok 0, error_sticky 0, captured_id 0, captured_ts 0, check_count 0, sysid_read 0, sysid_address 0, state IDLE, recheck counter reloaded.
- Latency: with start sampled at cycle 0, RD_ID covers cycles 1..L+1 and RD_TS covers L+2..2L+2. done pulses, and the new results are visible, in cycle 2L+3. For L = 0 that is cycle 3.
- Back-to-back checks: start held continuously gives a check every 2L+4 cycles (one IDLE cycle between checks).
- Reset mid-check: the FSM returns to IDLE the next cycle with all outputs at reset values. Partial captures are discarded. If AUTO_START = 1, the check restarts.
- id_ok, ts_ok and the captured words hold stable between done pulses.

## Test plan
- Reset release with AUTO_START = 1, L = 0, slave returning 31 / 1718188374:
  - sysid_read high in cycles 1–2, with address 0 then 1.
  - done in cycle 3.
  - id_ok = ts_ok = 1, error_sticky = 0, check_count = 1.
- Slave returns 30 at address 0:
  - id_ok = 0, ts_ok = 1, captured_id = 30, error_sticky = 1.
  - A following good check gives id_ok = 1 while error_sticky stays 1.
- L = 2, readdata valid only in the third read cycle (junk in the first two):
  - Captures are correct.
  - done arrives 7 cycles after start is sampled.
- RECHECK_PERIOD = 10, start never asserted: done pulses every 10 + 5 cycles (L = 0). After 300 checks, check_count stays at 255.
- start pulsed during RD_TS: no extra check; exactly one done pulse.
- Reset asserted during RD_ID:
  - Outputs are zeroed the next cycle.
  - The check restarts and completes normally 3 cycles after reset is released.

Source files
------------

// File: rtl/sysid_checker.sv
// Avalon-MM read master for the system ID slave: reads the ID and build
// timestamp words and flags a bitstream/software pairing mismatch.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd31,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1718188374,
  parameter int          READ_LATENCY       = 0,
  parameter int          AUTO_START         = 1,
  parameter int          RECHECK_PERIOD     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        error_sticky,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [7:0]  check_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_DONE
  } state_t;

  localparam logic [1:0]  LAT_LAST  = 2'(READ_LATENCY);
  localparam bit          RC_EN     = (RECHECK_PERIOD != 0);
  localparam logic [23:0] RC_RELOAD =
    RC_EN ? 24'(RECHECK_PERIOD - 1) : 24'd0;
  localparam bit          AUTO      = (AUTO_START != 0);

  state_t      state_q, state_d;
  logic [1:0]  lat_q, lat_d;
  logic [31:0] id_hold_q, id_hold_d;
  logic        pend_q, pend_d;
  logic [23:0] rc_q, rc_d;
  logic        rc_arm_q, rc_arm_d;
  logic        addr_q, addr_d;
  logic        read_q, read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        err_q, err_d;
  logic [31:0] cap_id_q, cap_id_d;
  logic [31:0] cap_ts_q, cap_ts_d;
  logic [7:0]  cnt_q, cnt_d;

  logic rc_run;
  logic expire;
  logic go;
  logic id_match;
  logic ts_match;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    id_hold_d = id_hold_q;
    pend_d    = pend_q;
    rc_d      = rc_q;
    rc_arm_d  = rc_arm_q;
    addr_d    = addr_q;
    read_d    = read_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    err_d     = err_q;
    cap_id_d  = cap_id_q;
    cap_ts_d  = cap_ts_q;
    cnt_d     = cnt_q;

    rc_run   = RC_EN && (cnt_q != 8'd0) && (state_q == S_IDLE) && rc_arm_q;
    expire   = rc_run && (rc_q == 24'd0);
    go       = start || pend_q;
    id_match = (id_hold_q == EXPECTED_ID);
    ts_match = (sysid_readdata == EXPECTED_TIMESTAMP);

    unique case (state_q)
      S_IDLE: begin
        // First idle cycle reloads the recheck counter; later ones count down.
        rc_arm_d = 1'b1;
        if (!rc_arm_q) begin
          rc_d = RC_RELOAD;
        end else if (rc_run && rc_q != 24'd0) begin
          rc_d = rc_q - 24'd1;
        end
        if (go) begin
          state_d  = S_RD_ID;
          lat_d    = 2'd0;
          pend_d   = 1'b0;
          rc_arm_d = 1'b0;
          read_d   = 1'b1;
          addr_d   = 1'b0;
          busy_d   = 1'b1;
        end else if (expire) begin
          pend_d = 1'b1;
        end
      end
      S_RD_ID: begin
        if (lat_q == LAT_LAST) begin
          id_hold_d = sysid_readdata;
          state_d   = S_RD_TS;
          lat_d     = 2'd0;
          addr_d    = 1'b1;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_RD_TS: begin
        if (lat_q == LAT_LAST) begin
          cap_id_d = id_hold_q;
          cap_ts_d = sysid_readdata;
          id_ok_d  = id_match;
          ts_ok_d  = ts_match;
          err_d    = err_q | ~(id_match & ts_match);
          cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          done_d   = 1'b1;
          read_d   = 1'b0;
          addr_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        read_d  = 1'b0;
        addr_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lat_q     <= 2'd0;
      id_hold_q <= 32'd0;
      pend_q    <= AUTO;
      rc_q      <= RC_RELOAD;
      rc_arm_q  <= 1'b0;
      addr_q    <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      err_q     <= 1'b0;
      cap_id_q  <= 32'd0;
      cap_ts_q  <= 32'd0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      id_hold_q <= id_hold_d;
      pend_q    <= pend_d;
      rc_q      <= rc_d;
      rc_arm_q  <= rc_arm_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      err_q     <= err_d;
      cap_id_q  <= cap_id_d;
      cap_ts_q  <= cap_ts_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sysid_address = addr_q;
  assign sysid_read    = read_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign id_ok         = id_ok_q;
  assign ts_ok         = ts_ok_q;
  assign error_sticky  = err_q;
  assign captured_id   = cap_id_q;
  assign captured_ts   = cap_ts_q;
  assign check_count   = cnt_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: three instances (L=0, L=2, periodic recheck)
// checked against cycle formulas and a small pass/fail model.
module tb_sysid_checker;

  localparam logic [31:0] EID = 32'd31;
  localparam logic [31:0] ETS = 32'd1718188374;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Instance 0: L=0, auto start, no recheck
  logic        rst0 = 1'b1, start0 = 1'b0;
  logic        addr0, read0, busy0, done0, idok0, tsok0, err0;
  logic [31:0] rdata0, capid0, capts0;
  logic [7:0]  cnt0;
  logic [31:0] sid0 = EID, sts0 = ETS;
  assign rdata0 = addr0 ? sts0 : sid0;

  sysid_checker u0 (
    .clock(clock), .reset(rst0), .start(start0),
    .sysid_address(addr0), .sysid_read(read0),
    .sysid_readdata(rdata0), .busy(busy0), .done(done0),
    .id_ok(idok0), .ts_ok(tsok0), .error_sticky(err0),
    .captured_id(capid0), .captured_ts(capts0),
    .check_count(cnt0)
  );

  // Instance 2: L=2, data valid only in the third cycle of each read
  logic        rst2 = 1'b1, start2 = 1'b0;
  logic        addr2, read2, busy2, done2, idok2, tsok2, err2;
  logic [31:0] rdata2, capid2, capts2;
  logic [7:0]  cnt2;
  logic [31:0] sid2 = EID, sts2 = ETS;
  logic [31:0] junk2_q = 32'h1;
  logic        prd2_q = 1'b0, pad2_q = 1'b0;
  int          idx2_q = 0;
  int          idx2;

  always_comb begin
    idx2 = 0;
    if (read2 && prd2_q && (pad2_q == addr2)) idx2 = idx2_q + 1;
  end

  assign rdata2 = (idx2 == 2) ? (addr2 ? sts2 : sid2)
                              : ((addr2 ? sts2 : sid2) ^ junk2_q);

  always @(posedge clock) begin
    idx2_q  <= idx2;
    prd2_q  <= read2;
    pad2_q  <= addr2;
    junk2_q <= $urandom | 32'h1;
  end

  sysid_checker #(.READ_LATENCY(2), .AUTO_START(0)) u2 (
    .clock(clock), .reset(rst2), .start(start2),
    .sysid_address(addr2), .sysid_read(read2),
    .sysid_readdata(rdata2), .busy(busy2), .done(done2),
    .id_ok(idok2), .ts_ok(tsok2), .error_sticky(err2),
    .captured_id(capid2), .captured_ts(capts2),
    .check_count(cnt2)
  );

  // Instance R: periodic recheck every 10 idle cycles
  logic        rstr = 1'b1;
  logic        startr = 1'b0;
  logic        addrr, readr, busyr, doner, idokr, tsokr, errr;
  logic [31:0] rdatar, capidr, captsr;
  logic [7:0]  cntr;
  assign rdatar = addrr ? ETS : EID;

  sysid_checker #(.RECHECK_PERIOD(10)) ur (
    .clock(clock), .reset(rstr), .start(startr),
    .sysid_address(addrr), .sysid_read(readr),
    .sysid_readdata(rdatar), .busy(busyr), .done(doner),
    .id_ok(idokr), .ts_ok(tsokr), .error_sticky(errr),
    .captured_id(capidr), .captured_ts(captsr),
    .check_count(cntr)
  );

  int exp_cnt0 = 0;
  int exp_err0 = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int n);
    return (n < 255) ? n + 1 : 255;
  endfunction

  // One start-triggered check on instance 0, optionally poking start in RD_TS
  task automatic run0(input logic [31:0] idv, input logic [31:0] tsv,
                      input bit poke);
    sid0 = idv;
    sts0 = tsv;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("c1_read", read0, 1);
    chk("c1_addr", addr0, 0);
    chk("c1_busy", busy0, 1);
    tick();
    chk("c2_read", read0, 1);
    chk("c2_addr", addr0, 1);
    if (poke) start0 = 1'b1;
    tick();
    start0 = 1'b0;
    exp_cnt0 = sat_inc(exp_cnt0);
    if (idv != EID || tsv != ETS) exp_err0 = 1;
    chk("c3_done", done0, 1);
    chk("c3_read", read0, 0);
    chk("c3_id_ok", idok0, (idv == EID));
    chk("c3_ts_ok", tsok0, (tsv == ETS));
    chk("c3_cap_id", capid0, idv);
    chk("c3_cap_ts", capts0, tsv);
    chk("c3_err", err0, exp_err0);
    chk("c3_cnt", cnt0, exp_cnt0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_done", done0, 0);
      chk("idle_busy", busy0, 0);
      chk("hold_id_ok", idok0, (idv == EID));
      chk("hold_cap_ts", capts0, tsv);
      chk("hold_cnt", cnt0, exp_cnt0);
    end
  endtask

  task automatic run2(input logic [31:0] idv, input logic [31:0] tsv);
    sid2 = idv;
    sts2 = tsv;
    start2 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      start2 = 1'b0;
      chk("l2_read", read2, (i <= 6));
      chk("l2_addr", addr2, (i >= 4 && i <= 6));
      chk("l2_done", done2, (i == 7));
    end
    chk("l2_cap_id", capid2, idv);
    chk("l2_cap_ts", capts2, tsv);
    chk("l2_id_ok", idok2, (idv == EID));
    chk("l2_ts_ok", tsok2, (tsv == ETS));
  endtask

  initial begin
    logic [31:0] idv;
    logic [31:0] tsv;
    int ndone;
    int last_done;
    int k;

    repeat (3) tick();
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_read", read0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_id_ok", idok0, 0);
    chk("rst_ts_ok", tsok0, 0);
    chk("rst_err", err0, 0);
    chk("rst_cap_id", capid0, 0);
    chk("rst_cap_ts", capts0, 0);
    chk("rst_cnt", cnt0, 0);

    // Reset release: auto start, cycle 0 is the first cycle with reset low
    rst0 = 1'b0;
    rst2 = 1'b0;
    tick();
    chk("auto_c1_read", read0, 1);
    chk("auto_c1_addr", addr0, 0);
    tick();
    chk("auto_c2_read", read0, 1);
    chk("auto_c2_addr", addr0, 1);
    tick();
    exp_cnt0 = 1;
    chk("auto_c3_done", done0, 1);
    chk("auto_c3_id_ok", idok0, 1);
    chk("auto_c3_ts_ok", tsok0, 1);
    chk("auto_c3_err", err0, 0);
    chk("auto_c3_cnt", cnt0, 1);
    tick();
    chk("auto_c4_done", done0, 0);
    chk("auto_c4_busy", busy0, 0);
    chk("l2_noauto", busy2, 0);
    tick();

    // Bad ID, then a good check: error stays sticky
    run0(32'd30, ETS, 1'b0);
    run0(EID, ETS, 1'b0);
    // start during RD_TS must not queue a second check
    run0(EID, ETS, 1'b1);

    for (int n = 0; n < 12; n++) begin
      idv = ($urandom_range(0, 2) == 0) ? $urandom : EID;
      tsv = ($urandom_range(0, 2) == 0) ? $urandom : ETS;
      run0(idv, tsv, ($urandom_range(0, 3) == 0));
    end

    // start held: one check every four cycles
    sid0 = EID;
    sts0 = ETS;
    start0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("b2b_done", done0, (i % 4 == 3));
      chk("b2b_busy", busy0, (i % 4 != 0));
    end
    start0 = 1'b0;
    exp_cnt0 = sat_inc(sat_inc(sat_inc(exp_cnt0)));
    tick();
    chk("b2b_cnt", cnt0, exp_cnt0);

    // Reset during RD_ID
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("mid_rdid", read0, 1);
    rst0 = 1'b1;
    tick();
    chk("mid_busy", busy0, 0);
    chk("mid_read", read0, 0);
    chk("mid_err", err0, 0);
    chk("mid_cnt", cnt0, 0);
    chk("mid_cap_id", capid0, 0);
    chk("mid_id_ok", idok0, 0);
    rst0 = 1'b0;
    exp_cnt0 = 0;
    exp_err0 = 0;
    tick();
    tick();
    chk("mid_c2_done", done0, 0);
    tick();
    chk("mid_c3_done", done0, 1);
    chk("mid_c3_cnt", cnt0, 1);
    chk("mid_c3_err", err0, 0);
    chk("mid_c3_id_ok", idok0, 1);

    // Read latency 2 with junk outside the valid cycle
    run2(EID, ETS);
    run2(32'd30, $urandom);
    run2($urandom, ETS);
    chk("l2_err", err2, 1);
    chk("l2_cnt", cnt2, 3);

    // Periodic rechecks: first done at cycle 3, then every 15 cycles
    rstr = 1'b0;
    ndone = 0;
    last_done = 0;
    for (int c = 1; c <= 3 + 299 * 15 + 5; c++) begin
      tick();
      k = c - 3;
      chk("rc_done", doner, (k >= 0 && k % 15 == 0));
      if (doner) begin
        ndone++;
        chk("rc_cnt", cntr, (ndone < 255) ? ndone : 255);
        chk("rc_id_ok", idokr, 1);
        last_done = c;
      end
    end
    chk("rc_total", ndone, 300);
    chk("rc_last", last_done, 3 + 299 * 15);
    chk("rc_sat", cntr, 255);
    chk("rc_err", errr, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
